// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: source IDs and
// the default number of implemented registers.
package rf_wb_arbiter_pkg;

    localparam int unsigned NREG_DEFAULT = 16;

    // Source identity doubles as the requester index inside the 2-way arbiter.
    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority to the requester that
// was not granted last. The last-grant flop only moves when a grant is issued.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e last;

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == SRC_LSU) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= SRC_LSU;
        end else if (|gnt) begin
            last <= gnt[1] ? SRC_LSU : SRC_EXU;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between EXU results and LSU load
// returns, and keeps a busy scoreboard of destinations with writes in flight.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREG       = NREG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid_i,
    output logic                  exu_ready_o,
    input  logic [ADDR_WIDTH-1:0] exu_rd_i,
    input  logic [DATA_WIDTH-1:0] exu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    output logic                  stall_o,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  idle_o
);

    localparam logic [ADDR_WIDTH-1:0] RD_MASK = ADDR_WIDTH'(NREG - 1);

    logic [1:0]            gnt;
    logic                  granted;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ADDR_WIDTH-1:0] wr_rd;
    logic [ADDR_WIDTH-1:0] set_rd;
    logic [ADDR_WIDTH-1:0] rs1_m;
    logic [ADDR_WIDTH-1:0] rs2_m;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;
    logic                  rs1_busy;
    logic                  rs2_busy;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({lsu_valid_i, exu_valid_i}),
        .gnt (gnt)
    );

    assign exu_ready_o = gnt[SRC_EXU];
    assign lsu_ready_o = gnt[SRC_LSU];
    assign granted     = |gnt;

    always_comb begin
        sel_rd   = exu_rd_i;
        sel_data = exu_data_i;
        if (gnt[SRC_LSU]) begin
            sel_rd   = lsu_rd_i;
            sel_data = lsu_data_i;
        end
    end

    assign wr_rd  = sel_rd & RD_MASK;
    assign set_rd = issue_rd_i & RD_MASK;
    assign rs1_m  = rs1_i & RD_MASK;
    assign rs2_m  = rs2_i & RD_MASK;

    // Staging register is rewritten every cycle; writes to x0 are accepted but suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_o   <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_wen_o   <= granted && (wr_rd != '0);
            rf_waddr_o <= granted ? wr_rd : '0;
            rf_wdata_o <= granted ? sel_data : '0;
        end
    end

    // Clear from the staged write first, then set from issue so a same-cycle set wins.
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rf_wen_o && (rf_waddr_o == ADDR_WIDTH'(i))) busy_next[i] = 1'b0;
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            if (issue_i && (set_rd == ADDR_WIDTH'(i))) busy_next[i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rs1_m == ADDR_WIDTH'(i)) rs1_busy = busy[i];
            if (rs2_m == ADDR_WIDTH'(i)) rs2_busy = busy[i];
        end
    end

    assign stall_o = rs1_busy | rs2_busy;
    assign idle_o  = ~|busy & ~rf_wen_o;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized check of rf_wb_arbiter against a transaction-level
// model of grant order, staged writes and the busy scoreboard.
module tb_rf_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          exu_valid = 1'b0;
    logic          exu_ready_o;
    logic [AW-1:0] exu_rd = '0;
    logic [DW-1:0] exu_data = '0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready_o;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          issue = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          stall_o;
    logic          rf_wen_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          idle_o;

    int checks = 0;
    int errors = 0;

    // Reference model: busy set per register, last granted source (0 EXU, 1 LSU), staged write.
    bit m_busy [NREG];
    int m_last;
    bit m_wen;
    int m_waddr;
    logic [DW-1:0] m_wdata;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .exu_valid_i (exu_valid),
        .exu_ready_o (exu_ready_o),
        .exu_rd_i    (exu_rd),
        .exu_data_i  (exu_data),
        .lsu_valid_i (lsu_valid),
        .lsu_ready_o (lsu_ready_o),
        .lsu_rd_i    (lsu_rd),
        .lsu_data_i  (lsu_data),
        .issue_i     (issue),
        .issue_rd_i  (issue_rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .stall_o     (stall_o),
        .rf_wen_o    (rf_wen_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .idle_o      (idle_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last  = 1;
        m_wen   = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
    endtask

    function automatic bit model_idle();
        bit any = 1'b0;
        foreach (m_busy[i]) any |= m_busy[i];
        return !any && !m_wen;
    endfunction

    // Called about 1ns after a rising edge with inputs already applied.
    task automatic cycle(output int g);
        int rdm;
        #3;
        if (exu_valid && lsu_valid) g = (m_last == 1) ? 0 : 1;
        else if (exu_valid)         g = 0;
        else if (lsu_valid)         g = 1;
        else                        g = -1;
        chk("exu_ready", exu_ready_o, g == 0);
        chk("lsu_ready", lsu_ready_o, g == 1);
        chk("stall", stall_o, m_busy[rs1 % NREG] | m_busy[rs2 % NREG]);
        chk("idle", idle_o, model_idle());
        @(posedge clk);
        #1;
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (issue) m_busy[issue_rd % NREG] = 1'b1;
        m_busy[0] = 1'b0;
        if (g >= 0) begin
            rdm     = ((g == 0) ? exu_rd : lsu_rd) % NREG;
            m_wen   = (rdm != 0);
            m_waddr = rdm;
            m_wdata = (g == 0) ? exu_data : lsu_data;
            m_last  = g;
        end else begin
            m_wen = 1'b0;
        end
        chk("rf_wen", rf_wen_o, m_wen);
        if (m_wen) begin
            chk("rf_waddr", rf_waddr_o, m_waddr);
            chk("rf_wdata", rf_wdata_o, m_wdata);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_wen", rf_wen_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_stall", stall_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic quiet();
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        issue     = 1'b0;
    endtask

    initial begin
        int g;
        int pat [4];
        model_reset();
        #1;
        do_reset();

        // EXU only: rd=3, 0xDEADBEEF
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hDEADBEEF;
        cycle(g);
        chk("t2_wen", rf_wen_o, 1);
        chk("t2_waddr", rf_waddr_o, 3);
        chk("t2_wdata", rf_wdata_o, 32'hDEADBEEF);
        quiet();
        cycle(g);
        chk("t2_wen_off", rf_wen_o, 0);

        // Reset while a write is staged, with a busy register being probed
        issue = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h1234_5678;
        cycle(g);
        quiet();
        chk("t1_pre_wen", rf_wen_o, 1);
        chk("t1_pre_stall", stall_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_async_wen", rf_wen_o, 0);
        chk("t1_async_idle", idle_o, 1);
        chk("t1_async_stall", stall_o, 0);
        do_reset();

        // Both valid from reset: EXU, LSU, EXU, LSU; losers hold rd/data
        pat = '{0, 1, 0, 1};
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'hE000_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hA000_0002;
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            chk("t3_order", g, pat[i]);
            if (g == 0) begin exu_rd = exu_rd + 5'd2; exu_data = exu_data + 32'd1; end
            else        begin lsu_rd = lsu_rd + 5'd2; lsu_data = lsu_data + 32'd1; end
        end
        quiet();
        cycle(g);
        do_reset();

        // Hazard on rd=5, including set-wins on a same-cycle clear
        issue = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd9;
        cycle(g);
        issue = 1'b0;
        cycle(g);
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h0000_00AA;
        cycle(g);
        exu_valid = 1'b0; issue = 1'b1; issue_rd = 5'd5;
        cycle(g);
        issue = 1'b0;
        chk("t4_set_wins", stall_o, 1);
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h0000_00BB;
        cycle(g);
        lsu_valid = 1'b0;
        chk("t4_stall_at_wen", stall_o, 1);
        cycle(g);
        chk("t4_stall_cleared", stall_o, 0);

        // rd=0: accepted, never written, never busy
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFF_FFFF;
        issue = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        cycle(g);
        quiet();
        chk("t5_wen_x0", rf_wen_o, 0);
        chk("t5_stall_x0", stall_o, 0);
        cycle(g);

        // rd=18 masks to 2
        issue = 1'b1; issue_rd = 5'd18; rs1 = 5'd2;
        cycle(g);
        issue = 1'b0;
        chk("t6_stall", stall_o, 1);
        chk("t6_idle_busy", idle_o, 0);
        exu_valid = 1'b1; exu_rd = 5'd18; exu_data = 32'h0000_0C0C;
        cycle(g);
        exu_valid = 1'b0;
        chk("t6_waddr", rf_waddr_o, 2);
        cycle(g);
        chk("t6_idle", idle_o, 1);

        // Randomized traffic; a source holds its request until granted
        for (int n = 0; n < 400; n++) begin
            cycle(g);
            if (!exu_valid || g == 0) begin
                exu_valid = ($urandom_range(0, 2) != 0);
                exu_rd    = AW'($urandom);
                exu_data  = $urandom;
            end
            if (!lsu_valid || g == 1) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = AW'($urandom);
                lsu_data  = $urandom;
            end
            issue    = ($urandom_range(0, 2) == 0);
            issue_rd = AW'($urandom);
            rs1      = AW'($urandom);
            rs2      = AW'($urandom);
        end
        quiet();
        for (int n = 0; n < 3; n++) cycle(g);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
